// File: rtl/lsu_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl_if
// Brief    : CPU request/response and word-wide memory port bundle for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  // slave: the controller; master: the CPU stage plus the memory it talks to
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    output mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_mem_ctrl
// Brief    : Single-outstanding load/store controller with lane steering and
//            two-beat splitting of word-crossing accesses.
// Revision : 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl #(
  parameter bit SPLIT_EN = 1'b1
) (
  input wire            clk,
  input wire            rst_n,
  lsu_mem_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    RESP  = 3'd5
  } state_t;

  state_t      r_state, w_state_nxt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_buf0;
  logic        r_req_ready, r_rsp_valid, r_rsp_err, r_mem_req, r_mem_we;
  logic [31:0] r_rsp_rdata, r_mem_addr, r_mem_wdata;
  logic [3:0]  r_mem_be;

  logic        w_req_ready_nxt, w_rsp_valid_nxt, w_rsp_err_nxt, w_mem_req_nxt, w_mem_we_nxt;
  logic [31:0] w_rsp_rdata_nxt, w_mem_addr_nxt, w_mem_wdata_nxt, w_buf0_nxt;
  logic [3:0]  w_mem_be_nxt;
  logic        w_latch;

  logic [31:0] w_src_addr;
  logic [2:0]  w_src_funct3;
  logic        w_src_we;
  logic [3:0]  w_size_mask;
  logic [7:0]  w_mask;
  logic        w_cross, w_bad_f3, w_illegal;
  logic [31:0] w_word0, w_word1, w_wdata_rot, w_aligned, w_load;
  logic [55:0] w_pair;

  // Decode from the live request while idle, from the latched copy afterwards
  always_comb begin
    w_src_addr   = (r_state == IDLE) ? bus.req_addr   : r_addr;
    w_src_funct3 = (r_state == IDLE) ? bus.req_funct3 : r_funct3;
    w_src_we     = (r_state == IDLE) ? bus.req_we     : r_we;
    case (w_src_funct3[1:0])
      2'b00:   w_size_mask = 4'b0001;
      2'b01:   w_size_mask = 4'b0011;
      default: w_size_mask = 4'b1111;
    endcase
    w_mask  = {4'b0000, w_size_mask} << w_src_addr[1:0];
    w_cross = |w_mask[7:4];
    w_word0 = {w_src_addr[31:2], 2'b00};
    w_word1 = w_word0 + 32'd4;
    if (w_src_we)
      w_bad_f3 = !(w_src_funct3 inside {3'b000, 3'b001, 3'b010});
    else
      w_bad_f3 = w_src_funct3 inside {3'b011, 3'b110, 3'b111};
    w_illegal = w_bad_f3 || (!SPLIT_EN && w_cross);
  end

  always_comb begin
    case (bus.req_addr[1:0])
      2'b00:   w_wdata_rot = bus.req_wdata;
      2'b01:   w_wdata_rot = {bus.req_wdata[23:0], bus.req_wdata[31:24]};
      2'b10:   w_wdata_rot = {bus.req_wdata[15:0], bus.req_wdata[31:16]};
      default: w_wdata_rot = {bus.req_wdata[7:0],  bus.req_wdata[31:8]};
    endcase
  end

  // Bytes above lane 6 of the two-beat window can never be selected
  always_comb begin
    w_pair = (r_state == WAIT1) ? {bus.mem_rdata[23:0], r_buf0} : {24'd0, bus.mem_rdata};
    case (r_addr[1:0])
      2'b00:   w_aligned = w_pair[31:0];
      2'b01:   w_aligned = w_pair[39:8];
      2'b10:   w_aligned = w_pair[47:16];
      default: w_aligned = w_pair[55:24];
    endcase
    case (r_funct3)
      3'b000:  w_load = {{24{w_aligned[7]}}, w_aligned[7:0]};
      3'b001:  w_load = {{16{w_aligned[15]}}, w_aligned[15:0]};
      3'b100:  w_load = {24'd0, w_aligned[7:0]};
      3'b101:  w_load = {16'd0, w_aligned[15:0]};
      default: w_load = w_aligned;
    endcase
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_req_ready_nxt  = 1'b0;
    w_rsp_valid_nxt  = 1'b0;
    w_rsp_err_nxt    = 1'b0;
    w_rsp_rdata_nxt  = 32'd0;
    w_mem_req_nxt    = 1'b0;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_be_nxt     = r_mem_be;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_buf0_nxt       = r_buf0;
    w_latch          = 1'b0;
    case (r_state)
      IDLE: begin
        w_req_ready_nxt = 1'b1;
        if (bus.req_valid) begin
          w_latch         = 1'b1;
          w_req_ready_nxt = 1'b0;
          if (w_illegal) begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
          end else begin
            w_state_nxt     = REQ0;
            w_mem_req_nxt   = 1'b1;
            w_mem_we_nxt    = bus.req_we;
            w_mem_addr_nxt  = w_word0;
            w_mem_be_nxt    = w_mask[3:0];
            w_mem_wdata_nxt = w_wdata_rot;
          end
        end
      end
      REQ0, REQ1: begin
        w_mem_req_nxt = 1'b1;
        if (r_mem_req && bus.mem_gnt) begin
          w_mem_req_nxt = 1'b0;
          w_state_nxt   = (r_state == REQ0) ? WAIT0 : WAIT1;
        end
      end
      WAIT0: begin
        if (bus.mem_rvalid) begin
          w_buf0_nxt = bus.mem_rdata;
          if (w_cross) begin
            w_state_nxt    = REQ1;
            w_mem_req_nxt  = 1'b1;
            w_mem_addr_nxt = w_word1;
            w_mem_be_nxt   = w_mask[7:4];
          end else begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_rdata_nxt = r_we ? 32'd0 : w_load;
          end
        end
      end
      WAIT1: begin
        if (bus.mem_rvalid) begin
          w_state_nxt     = RESP;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_rdata_nxt = r_we ? 32'd0 : w_load;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_req_ready_nxt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we        <= 1'b0;
      r_addr      <= 32'd0;
      r_funct3    <= 3'd0;
      r_buf0      <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_be    <= 4'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      if (w_latch) begin
        r_we     <= bus.req_we;
        r_addr   <= bus.req_addr;
        r_funct3 <= bus.req_funct3;
      end
      r_buf0      <= w_buf0_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_mem_req   <= w_mem_req_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_be    <= w_mem_be_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_be    = r_mem_be;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_mem_ctrl
// Brief    : Self-checking bench: directed vectors, corner sequences, random
//            traffic against a byte-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_ctrl;

  logic clk;
  logic rst_n;

  lsu_mem_ctrl_if bus1();
  lsu_mem_ctrl_if bus0();

  lsu_mem_ctrl #(.SPLIT_EN(1'b1)) u_dut  (.clk(clk), .rst_n(rst_n), .bus(bus1));
  lsu_mem_ctrl #(.SPLIT_EN(1'b0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } tx_t;

  typedef struct {
    bit          we;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic [31:0] pre0, pre1;
    int          nb;
    logic [31:0] a0;
    logic [3:0]  be0;
    logic [31:0] a1;
    logic [3:0]  be1;
    logic [31:0] wd, rdata;
    bit          err;
    int          lat;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  tx_t         txq[$];
  vec_t        vq[$];
  bit   [31:0] dmem [bit [31:0]];
  bit   [7:0]  ref_mem [bit [31:0]];
  int          gnt_delay = 0, rv_delay = 0, g_waited = 0;
  bit          rv_pend = 0;
  int          rv_left = 0;
  logic [31:0] rv_data = 0;
  bit          req0_seen = 0;

  int          got_lat;
  logic [31:0] got_rdata;
  logic        got_err;

  bit          m_err;
  logic [31:0] m_rdata, m_a0, m_a1, m_wd;
  logic [3:0]  m_be0, m_be1;
  int          m_nb, m_lat;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit [31:0] dmem_rd(input bit [31:0] a);
    return dmem.exists(a) ? dmem[a] : 32'd0;
  endfunction

  function automatic bit [7:0] ref_rd(input bit [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'd0;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    dmem[a] = v;
    for (int i = 0; i < 4; i++) ref_mem[a + i] = v[8*i +: 8];
  endtask

  // Memory slave: grants after gnt_delay idle request cycles, completes rv_delay cycles later
  initial begin
    bit [31:0] w;
    tx_t t;
    bus1.mem_gnt = 1'b0; bus1.mem_rvalid = 1'b0; bus1.mem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      bus1.mem_rvalid = 1'b0;
      if (rv_pend) begin
        if (rv_left == 0) begin
          bus1.mem_rvalid = 1'b1;
          bus1.mem_rdata  = rv_data;
          rv_pend = 1'b0;
        end else rv_left--;
      end
      bus1.mem_gnt = 1'b0;
      if (bus1.mem_req === 1'b1 && rst_n) begin
        if (g_waited < gnt_delay) g_waited++;
        else begin
          g_waited = 0;
          bus1.mem_gnt = 1'b1;
          t.addr = bus1.mem_addr; t.be = bus1.mem_be; t.we = bus1.mem_we; t.wdata = bus1.mem_wdata;
          txq.push_back(t);
          w = dmem_rd(t.addr);
          if (t.we) begin
            for (int k = 0; k < 4; k++) if (t.be[k]) w[8*k +: 8] = t.wdata[8*k +: 8];
            dmem[t.addr] = w;
            rv_data = $urandom;
          end else rv_data = w;
          rv_pend = 1'b1;
          rv_left = rv_delay;
        end
      end
    end
  end

  always @(negedge clk) if (bus0.mem_req === 1'b1) req0_seen = 1'b1;

  // Byte-level reference: walk the accessed bytes, group them by word
  task automatic model(input bit we, input logic [31:0] addr, wdata, input logic [2:0] f3);
    int sz, idx;
    logic [31:0] ba;
    logic [63:0] v;
    m_err = 0; m_rdata = 0; m_nb = 0; m_a0 = 0; m_a1 = 0; m_be0 = 0; m_be1 = 0; m_wd = 0; m_lat = 1;
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we ? !(f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd3, 3'd6, 3'd7})) begin
      m_err = 1;
      return;
    end
    m_a0 = addr & ~32'd3;
    v = 0;
    for (int i = 0; i < sz; i++) begin
      ba = addr + i;
      if ((ba & ~32'd3) == m_a0) m_be0[ba[1:0]] = 1'b1;
      else begin m_a1 = ba & ~32'd3; m_be1[ba[1:0]] = 1'b1; end
      if (we) ref_mem[ba] = wdata[8*i +: 8];
      else v = v | (64'(ref_rd(ba)) << (8*i));
    end
    if (!we) begin
      if (!f3[2] && v[8*sz-1]) v = v | (~64'd0 << (8*sz));
      m_rdata = v[31:0];
    end
    for (int k = 0; k < 4; k++) begin
      idx = (k - int'(addr[1:0])) & 3;
      m_wd[8*k +: 8] = wdata[8*idx +: 8];
    end
    m_nb  = (m_be1 != 0) ? 2 : 1;
    m_lat = 1 + m_nb * (gnt_delay + rv_delay + 2);
  endtask

  task automatic do_req(input bit we, input logic [31:0] addr, wdata, input logic [2:0] f3);
    int n;
    got_lat = -1; got_rdata = 'x; got_err = 'x; n = 0;
    @(negedge clk);
    while (bus1.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (bus1.req_ready !== 1'b1) begin
      chk("req_ready timeout", {31'd0, bus1.req_ready}, 32'd1);
      return;
    end
    bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_addr = addr;
    bus1.req_wdata = wdata; bus1.req_funct3 = f3;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      bus1.req_valid = 1'b0;
      if (bus1.rsp_valid === 1'b1) begin
        got_lat = c; got_rdata = bus1.rsp_rdata; got_err = bus1.rsp_err;
        break;
      end
    end
  endtask

  task automatic check_tx(input string tag, input int nb, input logic [31:0] a0, input logic [3:0] be0,
                          input logic [31:0] a1, input logic [3:0] be1, input bit we, input logic [31:0] wd);
    chk({tag, " beats"}, txq.size(), nb);
    for (int b = 0; b < nb && b < txq.size(); b++) begin
      chk({tag, " addr"}, txq[b].addr, (b == 0) ? a0 : a1);
      chk({tag, " be"}, {28'd0, txq[b].be}, {28'd0, (b == 0) ? be0 : be1});
      chk({tag, " we"}, {31'd0, txq[b].we}, {31'd0, we});
      if (we) chk({tag, " wdata"}, txq[b].wdata, wd);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " req_ready"}, {31'd0, bus1.req_ready}, 32'd1);
    chk({tag, " rsp_valid"}, {31'd0, bus1.rsp_valid}, 32'd0);
    chk({tag, " rsp_err"},   {31'd0, bus1.rsp_err},   32'd0);
    chk({tag, " rsp_rdata"}, bus1.rsp_rdata, 32'd0);
    chk({tag, " mem_req"},   {31'd0, bus1.mem_req},   32'd0);
    chk({tag, " mem_we"},    {31'd0, bus1.mem_we},    32'd0);
    chk({tag, " mem_addr"},  bus1.mem_addr,  32'd0);
    chk({tag, " mem_be"},    {28'd0, bus1.mem_be}, 32'd0);
    chk({tag, " mem_wdata"}, bus1.mem_wdata, 32'd0);
  endtask

  task automatic add_vec(input bit we, input logic [31:0] addr, wdata, input logic [2:0] f3,
                         input logic [31:0] pre0, pre1, input int nb, input logic [31:0] a0,
                         input logic [3:0] be0, input logic [31:0] a1, input logic [3:0] be1,
                         input logic [31:0] wd, rdata, input bit err, input int lat);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.f3 = f3; v.pre0 = pre0; v.pre1 = pre1;
    v.nb = nb; v.a0 = a0; v.be0 = be0; v.a1 = a1; v.be1 = be1; v.wd = wd; v.rdata = rdata;
    v.err = err; v.lat = lat;
    vq.push_back(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h_wd;
    int          pulses;
    bit          we;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;
    logic [2:0]  legal_f3 [5];
    logic [2:0]  bad_f3 [3];
    string       tag;

    legal_f3[0] = 3'd0; legal_f3[1] = 3'd1; legal_f3[2] = 3'd2; legal_f3[3] = 3'd4; legal_f3[4] = 3'd5;
    bad_f3[0] = 3'd3; bad_f3[1] = 3'd6; bad_f3[2] = 3'd7;

    //        we addr          wdata         f3 pre0          pre1          nb a0            be0 a1            be1 wd            rdata         err lat
    add_vec(0, 32'h100,      32'h0,        2, 32'h8899AABB, 32'h0,        1, 32'h100,      4'hF, 32'h0,        4'h0, 32'h0,        32'h8899AABB, 0, 3);
    add_vec(0, 32'h203,      32'h0,        0, 32'h80123456, 32'h0,        1, 32'h200,      4'h8, 32'h0,        4'h0, 32'h0,        32'hFFFFFF80, 0, 3);
    add_vec(0, 32'h203,      32'h0,        4, 32'h80123456, 32'h0,        1, 32'h200,      4'h8, 32'h0,        4'h0, 32'h0,        32'h00000080, 0, 3);
    add_vec(1, 32'h102,      32'h11223344, 2, 32'h0,        32'h0,        2, 32'h100,      4'hC, 32'h104,      4'h3, 32'h33441122, 32'h0,        0, 5);
    add_vec(0, 32'h0FF,      32'h0,        1, 32'hAB000000, 32'h000000CD, 2, 32'h0FC,      4'h8, 32'h100,      4'h1, 32'h0,        32'hFFFFCDAB, 0, 5);
    add_vec(0, 32'h101,      32'h0,        5, 32'h12F45678, 32'h0,        1, 32'h100,      4'h6, 32'h0,        4'h0, 32'h0,        32'h0000F456, 0, 3);
    add_vec(0, 32'h101,      32'h0,        1, 32'h12F45678, 32'h0,        1, 32'h100,      4'h6, 32'h0,        4'h0, 32'h0,        32'hFFFFF456, 0, 3);
    add_vec(0, 32'hFFFFFFFE, 32'h0,        2, 32'h1234ABCD, 32'h56789ABC, 2, 32'hFFFFFFFC, 4'hC, 32'h0,        4'h3, 32'h0,        32'h9ABC1234, 0, 5);
    add_vec(1, 32'h101,      32'h000000A5, 0, 32'h0,        32'h0,        1, 32'h100,      4'h2, 32'h0,        4'h0, 32'h0000A500, 32'h0,        0, 3);
    add_vec(1, 32'h103,      32'h0000BEEF, 1, 32'h0,        32'h0,        2, 32'h100,      4'h8, 32'h104,      4'h1, 32'hEF0000BE, 32'h0,        0, 5);
    add_vec(0, 32'h100,      32'h0,        3, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 1);
    add_vec(1, 32'h100,      32'h1,        4, 32'h0,        32'h0,        0, 32'h0,        4'h0, 32'h0,        4'h0, 32'h0,        32'h0,        1, 1);

    bus1.req_valid = 0; bus1.req_we = 0; bus1.req_addr = 0; bus1.req_wdata = 0; bus1.req_funct3 = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0; bus0.req_funct3 = 0;
    bus0.mem_gnt = 0; bus0.mem_rvalid = 0; bus0.mem_rdata = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    foreach (vq[i]) begin
      tag = $sformatf("vec%0d", i);
      if (vq[i].nb >= 1) preload(vq[i].a0, vq[i].pre0);
      if (vq[i].nb == 2) preload(vq[i].a1, vq[i].pre1);
      txq.delete();
      do_req(vq[i].we, vq[i].addr, vq[i].wdata, vq[i].f3);
      chk({tag, " latency"}, got_lat, vq[i].lat);
      chk({tag, " rdata"}, got_rdata, vq[i].rdata);
      chk({tag, " err"}, {31'd0, got_err}, {31'd0, vq[i].err});
      check_tx(tag, vq[i].nb, vq[i].a0, vq[i].be0, vq[i].a1, vq[i].be1, vq[i].we, vq[i].wd);
    end

    // Grant withheld for three cycles: request fields must not move
    preload(32'h100, 32'h8899AABB);
    gnt_delay = 3; rv_delay = 0; g_waited = 0; txq.delete();
    @(negedge clk);
    bus1.req_valid = 1; bus1.req_we = 0; bus1.req_addr = 32'h100;
    bus1.req_wdata = 32'h5A5A5A5A; bus1.req_funct3 = 3'd2;
    @(negedge clk);
    h_wd = bus1.mem_wdata;
    got_lat = -1;
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) @(negedge clk);
      chk("stall mem_req",   {31'd0, bus1.mem_req},   32'd1);
      chk("stall mem_addr",  bus1.mem_addr,  32'h100);
      chk("stall mem_be",    {28'd0, bus1.mem_be}, 32'hF);
      chk("stall mem_we",    {31'd0, bus1.mem_we},    32'd0);
      chk("stall mem_wdata", bus1.mem_wdata, h_wd);
      chk("stall req_ready", {31'd0, bus1.req_ready}, 32'd0);
    end
    bus1.req_valid = 0;
    for (int c = 4; c <= 40; c++) begin
      @(negedge clk);
      if (bus1.rsp_valid === 1'b1) begin got_lat = c; got_rdata = bus1.rsp_rdata; break; end
    end
    chk("stall latency", got_lat, 6);
    chk("stall rdata", got_rdata, 32'h8899AABB);
    chk("stall beats", txq.size(), 1);
    gnt_delay = 0;

    // Split disabled: crossing halfword errors out without touching memory
    req0_seen = 0;
    @(negedge clk);
    bus0.req_valid = 1; bus0.req_we = 0; bus0.req_addr = 32'h0FF; bus0.req_funct3 = 3'd1;
    @(negedge clk);
    bus0.req_valid = 0;
    chk("nosplit rsp_valid", {31'd0, bus0.rsp_valid}, 32'd1);
    chk("nosplit rsp_err",   {31'd0, bus0.rsp_err},   32'd1);
    chk("nosplit rsp_rdata", bus0.rsp_rdata, 32'd0);
    repeat (3) @(negedge clk);
    chk("nosplit mem_req seen", {31'd0, req0_seen}, 32'd0);

    // Reset while the load waits for its data; the late rvalid must be ignored
    rv_delay = 4; txq.delete();
    @(negedge clk);
    bus1.req_valid = 1; bus1.req_we = 0; bus1.req_addr = 32'h100; bus1.req_funct3 = 3'd2;
    @(negedge clk);
    bus1.req_valid = 0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus1.rsp_valid === 1'b1) pulses++;
    end
    chk("post-reset rsp pulses", pulses, 0);
    rv_delay = 0; txq.delete();
    do_req(0, 32'h100, 32'h0, 3'd2);
    chk("post-reset latency", got_lat, 3);
    chk("post-reset rdata", got_rdata, 32'h8899AABB);
    check_tx("post-reset", 1, 32'h100, 4'hF, 32'h0, 4'h0, 0, 32'h0);

    // Random traffic against the byte-level model
    for (int a = 32'h1000; a < 32'h1044; a += 4) preload(a, $urandom);
    preload(32'hFFFFFFF8, $urandom); preload(32'hFFFFFFFC, $urandom); preload(32'h0, $urandom);
    for (int i = 0; i < 200; i++) begin
      we    = $urandom_range(0, 1);
      addr  = ($urandom_range(0, 15) == 0) ? (32'hFFFFFFF8 + $urandom_range(0, 7))
                                           : (32'h1000 + $urandom_range(0, 63));
      wdata = $urandom;
      f3    = ($urandom_range(0, 19) < 17) ? legal_f3[$urandom_range(0, 4)] : bad_f3[$urandom_range(0, 2)];
      gnt_delay = $urandom_range(0, 2);
      rv_delay  = $urandom_range(0, 2);
      model(we, addr, wdata, f3);
      txq.delete();
      do_req(we, addr, wdata, f3);
      tag = $sformatf("rnd%0d", i);
      chk({tag, " latency"}, got_lat, m_lat);
      chk({tag, " rdata"}, got_rdata, m_rdata);
      chk({tag, " err"}, {31'd0, got_err}, {31'd0, m_err});
      check_tx(tag, m_nb, m_a0, m_be0, m_a1, m_be1, we, m_wd);
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store unit controller between the CPU memory stage and a word-wide data memory port with a req/gnt/rvalid handshake.
- Accepts one load or store at a time.
- Produces byte enables, lane-shifted write data, and sign/zero-extended read data.
- Splits word-crossing misaligned halfword/word accesses into two aligned word transactions and merges the results.

Parameters:
- SPLIT_EN, 1: 1 = split misaligned crossing accesses into two beats; 0 = misaligned access returns rsp_err with no memory traffic.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  CPU request valid
- req_ready  output  1  controller can accept a request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_wdata  input  32  store data, right-justified
- req_funct3  input  3  RV32 size/sign encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  extended load data; 0 for stores and errors
- rsp_err  output  1  illegal funct3, or misaligned access with SPLIT_EN=0; valid with rsp_valid
- mem_req  output  1  memory transaction request
- mem_gnt  input  1  memory accepts the request this cycle
- mem_we  output  1  write strobe
- mem_addr  output  32  word-aligned address; [1:0] always 00
- mem_be  output  4  byte lane enables
- mem_wdata  output  32  lane-aligned write data
- mem_rvalid  input  1  completion of the outstanding transaction, for loads and stores
- mem_rdata  input  32  read word, valid with mem_rvalid

Behaviour:
- Reset (async, any state): state IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_rdata=0; mem_req=0; mem_we=0; mem_addr=0; mem_be=0; mem_wdata=0.
- A transaction in flight at reset is dropped. The memory side must discard it.
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch we/addr/wdata/funct3.
  - o = addr[1:0]; S = 1/2/4 bytes.
  - Illegal: load funct3 in {011,110,111}; store funct3 not in {000,001,010}; SPLIT_EN=0 with o+S>4.
  - Illegal -> RESP with err=1.
  - Otherwise -> REQ0.
- REQ0/REQ1: mem_req=1. addr/be/we/wdata are held stable until mem_gnt. On gnt -> WAIT0 / WAIT1.
- WAIT0: on mem_rvalid, capture rdata into buf0. If crossing -> REQ1, else -> RESP.
- WAIT1: on mem_rvalid, capture buf1 -> RESP.
- RESP: rsp_valid=1 for exactly one cycle -> IDLE. No response backpressure. req_ready=0 in every state but IDLE.
- Lane mask M = (S==1 ? 0001 : S==2 ? 0011 : 1111) << o, 8 bits.
  - Beat0: mem_addr = {addr[31:2],00}, mem_be = M[3:0].
  - Beat1: mem_addr = {addr[31:2],00} + 4 (32-bit wrap at 0xFFFFFFFC -> 0), mem_be = M[7:4].
  - Crossing iff M[7:4] != 0.
- Store data: mem_wdata = req_wdata rotated left by 8*o, identical for both beats.
- Load data: D = ({buf1, buf0} >> 8*o)[S*8-1:0]; buf1 = 0 when not crossing.
  - Sign-extend for 000/001, zero-extend for 100/101.
- Registered outputs. mem_rvalid is ignored outside WAIT states. mem_gnt is ignored unless mem_req=1.
- Latency, aligned, zero wait: accept at edge E0 -> mem_req high until E1 (gnt) -> rvalid at E2 -> rsp_valid during the cycle after E2 -> req_ready after E3.
- Each memory wait cycle adds one cycle.

Test Plan:
- LW 0x100, gnt immediate, rdata 0x8899AABB next cycle -> one beat addr 0x100 be 1111; rsp_rdata 0x8899AABB, err 0; rsp_valid 3 cycles after accept.
- LB 0x203, rdata 0x80123456 -> be 1000, rsp_rdata 0xFFFFFF80. Same with LBU -> 0x00000080.
- SW 0x102 wdata 0x11223344 -> beat0 addr 0x100 be 1100 wdata 0x33441122; beat1 addr 0x104 be 0011 wdata 0x33441122; rsp_rdata 0.
- LH 0x0FF, beat0 rdata 0xAB000000 (addr 0x0FC be 1000), beat1 rdata 0x000000CD (addr 0x100 be 0001) -> rsp_rdata 0xFFFFCDAB. Same with SPLIT_EN=0 -> rsp_err=1, mem_req never asserted.
- mem_gnt low 3 cycles in REQ0 -> mem_addr/be/wdata/we constant; req_ready stays 0 with req_valid held high. Illegal load funct3 011 -> rsp_err=1 within 2 cycles, no mem_req.
- rst_n low while in WAIT0 -> all outputs at reset values immediately. Later mem_rvalid produces no rsp_valid; next LW completes normally.
